// File: rtl/semafor_pkg.sv
// Shared definitions for the vehicle and pedestrian light controllers:
// FSM state encoding and default timing constants.
package semafor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VERDE,
        GALBEN,
        ROSU_SIG,
        DONE
    } state_t;

    localparam int DEF_DIV_FACTOR_SEC         = 10000000;
    localparam int DEF_SECUNDE_VERDE          = 28;
    localparam int DEF_SECUNDE_GALBEN         = 3;
    localparam int DEF_SECUNDE_ROSU_SIGURANTA = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tick_gen_sec.sv
// One-second prescaler: tick is high during the last cycle of each
// DIV_FACTOR_SEC-cycle period; clr restarts the period from zero.
module tick_gen_sec
    import semafor_pkg::*;
#(
    parameter int DIV_FACTOR_SEC = DEF_DIV_FACTOR_SEC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV_FACTOR_SEC > 1) ? $clog2(DIV_FACTOR_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV_FACTOR_SEC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/semafor_directie.sv
// Per-direction vehicle lamp controller: green -> yellow -> safety red -> done.
// Optional SEMAFOR_SERVICE_EN adds a service input that blinks yellow at 1 Hz.
module semafor_directie
    import semafor_pkg::*;
#(
    parameter int DIV_FACTOR_SEC         = DEF_DIV_FACTOR_SEC,
    parameter int SECUNDE_VERDE          = DEF_SECUNDE_VERDE,
    parameter int SECUNDE_GALBEN         = DEF_SECUNDE_GALBEN,
    parameter int SECUNDE_ROSU_SIGURANTA = DEF_SECUNDE_ROSU_SIGURANTA
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
`ifdef SEMAFOR_SERVICE_EN
    input  logic service,
`endif
    output logic done,
    output logic verde,
    output logic galben,
    output logic rosu
);

    localparam int SW = $clog2(max3(SECUNDE_VERDE, SECUNDE_GALBEN, SECUNDE_ROSU_SIGURANTA) + 1);
    localparam logic [SW-1:0] V_LAST = SW'(SECUNDE_VERDE - 1);
    localparam logic [SW-1:0] G_LAST = SW'(SECUNDE_GALBEN - 1);
    localparam logic [SW-1:0] R_LAST = SW'((SECUNDE_ROSU_SIGURANTA > 0) ? SECUNDE_ROSU_SIGURANTA - 1 : 0);

    state_t        state;
    logic [SW-1:0] sec;
    logic [SW-1:0] sec_last;
    logic          tick;
    logic          phase_end;
    logic          clr;

`ifdef SEMAFOR_SERVICE_EN
    localparam int BW = (DIV_FACTOR_SEC > 1) ? $clog2(DIV_FACTOR_SEC) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(DIV_FACTOR_SEC - 1);
    localparam logic [BW-1:0] BLINK_HALF = BW'(DIV_FACTOR_SEC / 2);

    logic          in_service;
    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_nxt;
    logic          blink_on;

    // blink_cnt is the position within the current second; entry restarts at 0
    always_comb begin
        blink_nxt = '0;
        if (in_service)
            blink_nxt = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
        blink_on = (blink_nxt < BLINK_HALF);
    end
`endif

    always_comb begin
        sec_last = '0;
        case (state)
            VERDE:    sec_last = V_LAST;
            GALBEN:   sec_last = G_LAST;
            ROSU_SIG: sec_last = R_LAST;
            default:  sec_last = '0;
        endcase
        phase_end = tick && (sec == sec_last);
        // Holding the prescaler cleared in IDLE/DONE aligns the next phase start
        clr = (state == IDLE) || (state == DONE) || clear || phase_end;
`ifdef SEMAFOR_SERVICE_EN
        clr = clr || service || in_service;
`endif
    end

    tick_gen_sec #(
        .DIV_FACTOR_SEC(DIV_FACTOR_SEC)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sec    <= '0;
            verde  <= 1'b0;
            galben <= 1'b0;
            rosu   <= 1'b1;
            done   <= 1'b0;
`ifdef SEMAFOR_SERVICE_EN
            in_service <= 1'b0;
            blink_cnt  <= '0;
`endif
        end else begin
            if (clr)
                sec <= '0;
            else if (tick)
                sec <= sec + 1'b1;
`ifdef SEMAFOR_SERVICE_EN
            in_service <= service;
            if (service) begin
                state     <= IDLE;
                verde     <= 1'b0;
                rosu      <= 1'b0;
                done      <= 1'b0;
                blink_cnt <= blink_nxt;
                galben    <= blink_on;
            end else if (in_service) begin
                // release cycle: park in IDLE before honouring enable
                state  <= IDLE;
                verde  <= 1'b0;
                galben <= 1'b0;
                rosu   <= 1'b1;
                done   <= 1'b0;
            end else
`endif
            if (clear) begin
                state  <= IDLE;
                verde  <= 1'b0;
                galben <= 1'b0;
                rosu   <= 1'b1;
                done   <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (enable) begin
                        state <= VERDE;
                        verde <= 1'b1;
                        rosu  <= 1'b0;
                    end
                    VERDE: if (phase_end) begin
                        state  <= GALBEN;
                        verde  <= 1'b0;
                        galben <= 1'b1;
                    end
                    GALBEN: if (phase_end) begin
                        galben <= 1'b0;
                        rosu   <= 1'b1;
                        if (SECUNDE_ROSU_SIGURANTA == 0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ROSU_SIG;
                        end
                    end
                    ROSU_SIG: if (phase_end) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                    DONE: state <= DONE;
                    default: begin
                        state  <= IDLE;
                        verde  <= 1'b0;
                        galben <= 1'b0;
                        rosu   <= 1'b1;
                        done   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
